// File: rtl/mult_pkg.sv
// Shared types, constants and helpers for the iterative multiplier.
package mult_pkg;

    localparam int unsigned MULT_CYCLES = 32;
    localparam int unsigned MULT_CNT_W  = 6;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MLA   = 2'b01,
        OP_UMULL = 2'b10,
        OP_SMULL = 2'b11
    } mult_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } mult_state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is the
    // correct unsigned magnitude of the most negative value.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Long ops produce a 64-bit result and 64-bit flags.
    function automatic logic is_long(input mult_op_t op);
        return (op == OP_UMULL) || (op == OP_SMULL);
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Operand registers, shift-add accumulator, sign correction and MLA add.
module mult_datapath
    import mult_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [MULT_CNT_W-1:0] i_cnt,
    input  logic [31:0]           i_src1,
    input  logic [31:0]           i_src2,
    input  logic [31:0]           i_acc,
    input  logic [1:0]            i_op,
    output logic [63:0]           o_final,
    output logic                  o_long
);

    mult_op_t    r_op;
    logic [31:0] r_mplier;
    logic [31:0] r_mcand;
    logic [31:0] r_acc;
    logic        r_neg;
    logic [63:0] r_prod;

    mult_op_t    w_op_in;
    logic [63:0] w_addend;
    logic [63:0] w_sum;
    logic [31:0] w_lo32;

    assign w_op_in = mult_op_t'(i_op);

    // Latch operands on accept; one shift-add step per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_mplier <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_prod   <= '0;
        end else if (i_load) begin
            r_op   <= w_op_in;
            r_acc  <= i_acc;
            r_prod <= '0;
            if (w_op_in == OP_SMULL) begin
                r_mplier <= abs32(i_src1);
                r_mcand  <= abs32(i_src2);
                r_neg    <= i_src1[31] ^ i_src2[31];
            end else begin
                r_mplier <= i_src1;
                r_mcand  <= i_src2;
                r_neg    <= 1'b0;
            end
        end else if (i_step) begin
            r_prod   <= w_sum;
            r_mplier <= r_mplier >> 1;
        end
    end

    // Product including this cycle's partial term, so the last step's result is
    // available on the same edge that registers the outputs.
    always_comb begin
        w_addend = r_mplier[0] ? ({32'h0, r_mcand} << i_cnt) : 64'h0;
        w_sum    = r_prod + w_addend;
    end

    // Final value per operation.
    always_comb begin
        o_final = 64'h0;
        w_lo32  = w_sum[31:0] + r_acc;
        unique case (r_op)
            OP_MUL:   o_final = {32'h0, w_sum[31:0]};
            OP_MLA:   o_final = {32'h0, w_lo32};
            OP_UMULL: o_final = w_sum;
            OP_SMULL: o_final = r_neg ? (~w_sum + 64'd1) : w_sum;
            default:  o_final = 64'h0;
        endcase
    end

    assign o_long = is_long(r_op);

endmodule

// File: rtl/mult_unit.sv
// Iterative 32x32 multiplier: FSM, iteration counter and output registers.
module mult_unit
    import mult_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [31:0] acc,
    input  logic [1:0]  op,
    input  logic        start,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        n_flag,
    output logic        z_flag
);

    mult_state_t           r_state;
    logic [MULT_CNT_W-1:0] r_cnt;
    logic [31:0]           r_lo;
    logic [31:0]           r_hi;
    logic                  r_n;
    logic                  r_z;

    logic                  w_load;
    logic                  w_step;
    logic                  w_last;
    logic                  w_long;
    logic [63:0]           w_final;

    // Flush beats start in IDLE; flush in CALC stops the accumulator too.
    assign w_load = (r_state == S_IDLE) && start && !flush;
    assign w_step = (r_state == S_CALC) && !flush;
    assign w_last = (r_cnt == MULT_CNT_W'(MULT_CYCLES - 1));

    mult_datapath u_datapath (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_cnt   (r_cnt),
        .i_src1  (src1),
        .i_src2  (src2),
        .i_acc   (acc),
        .i_op    (op),
        .o_final (w_final),
        .o_long  (w_long)
    );

    // FSM, counter, and result/flag registers updated only on CALC->DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state <= S_CALC;
                        r_cnt   <= '0;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                        r_lo    <= w_final[31:0];
                        r_hi    <= w_final[63:32];
                        r_n     <= w_long ? w_final[63] : w_final[31];
                        r_z     <= w_long ? (w_final == 64'h0) : (w_final[31:0] == 32'h0);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == S_CALC);
    assign done      = (r_state == S_DONE);
    assign result_lo = r_lo;
    assign result_hi = r_hi;
    assign n_flag    = r_n;
    assign z_flag    = r_z;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed cases plus random ops against
// a plain-arithmetic reference model.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [31:0] acc = '0;
    logic [1:0]  op = '0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        n_flag;
    logic        z_flag;

    int n_asserts = 0;
    int n_fail    = 0;

    // Expected held outputs
    logic [31:0] e_lo = '0;
    logic [31:0] e_hi = '0;
    logic        e_n  = 1'b0;
    logic        e_z  = 1'b0;

    mult_unit dut (
        .clk       (clk),
        .rst       (rst),
        .src1      (src1),
        .src2      (src2),
        .acc       (acc),
        .op        (op),
        .start     (start),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .n_flag    (n_flag),
        .z_flag    (z_flag)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_lo"}, 64'(result_lo), 64'(e_lo));
        chk({tag, "_hi"}, 64'(result_hi), 64'(e_hi));
        chk({tag, "_n"}, 64'(n_flag), 64'(e_n));
        chk({tag, "_z"}, 64'(z_flag), 64'(e_z));
    endtask

    // Reference: straight arithmetic on the architectural definition.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
        logic [63:0]        p;
        logic [31:0]        t32;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        case (o)
            2'b00: begin t32 = a * b;     p = {32'h0, t32}; end
            2'b01: begin t32 = a * b + c; p = {32'h0, t32}; end
            2'b10: p = {32'h0, a} * {32'h0, b};
            default: begin
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                p  = sa * sb;
            end
        endcase
        e_lo = p[31:0];
        e_hi = p[63:32];
        e_n  = o[1] ? p[63] : p[31];
        e_z  = o[1] ? (p == 64'h0) : (p[31:0] == 32'h0);
    endtask

    // One full operation; s2 > 0 pulses a second start (9x9) in that CALC cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input int s2);
        int nbusy = 0;
        int ndone = 0;
        int nhold = 0;
        op = o; src1 = a; src2 = b; acc = c; start = 1'b1;
        tick;
        start = 1'b0;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            if (busy === 1'b1) nbusy++;
            if (done !== 1'b0) ndone++;
            if ({result_hi, result_lo, n_flag, z_flag} !== {e_hi, e_lo, e_n, e_z}) nhold++;
            if (cyc == s2) begin
                start = 1'b1; src1 = 32'd9; src2 = 32'd9;
            end else begin
                start = 1'b0;
            end
            tick;
        end
        start = 1'b0;
        chk("busy_cycles", 64'(nbusy), 64'd32);
        chk("early_done", 64'(ndone), 64'd0);
        chk("hold_during_calc", 64'(nhold), 64'd0);
        model(o, a, b, c);
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd0);
        chk_outs("res");
        tick;
        chk("done_len", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk_outs("held");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        // Reset state
        tick;
        tick;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk_outs("rst");
        rst = 1'b0;
        tick;

        // Directed cases
        run_op(2'b00, 32'd3, 32'd5, 32'd0, 0);
        chk("mul_lit_lo", 64'(result_lo), 64'h0000000F);
        run_op(2'b01, 32'hFFFFFFFF, 32'd2, 32'd1, 0);
        chk("mla_lit_lo", 64'(result_lo), 64'hFFFFFFFF);
        chk("mla_lit_n", 64'(n_flag), 64'd1);
        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 0);
        chk("umull_lit", {32'(result_hi), 32'(result_lo)}, 64'hFFFFFFFE_00000001);
        run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 0);
        chk("smull_m1", {32'(result_hi), 32'(result_lo)}, 64'h1);
        run_op(2'b11, 32'd0, 32'h12345678, 32'd0, 0);
        chk("smull_zero_z", 64'(z_flag), 64'd1);
        run_op(2'b11, 32'h80000000, 32'd2, 32'd0, 0);
        chk("smull_min", {32'(result_hi), 32'(result_lo)}, 64'hFFFFFFFF_00000000);

        // Start during CALC is ignored and not queued
        run_op(2'b10, 32'd7, 32'd6, 32'd0, 10);
        chk("ign_start_lo", 64'(result_lo), 64'd42);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b0 || done !== 1'b0) nd++;
            tick;
        end
        chk("no_second_op", 64'(nd), 64'd0);

        // Flush at cycle 12
        op = 2'b00; src1 = 32'd4; src2 = 32'd4; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (11) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) nd++;
            tick;
        end
        chk("flush_no_done", 64'(nd), 64'd0);
        chk_outs("flush_keep");

        // Flush beats start in IDLE
        start = 1'b1; flush = 1'b1;
        tick;
        start = 1'b0; flush = 1'b0;
        chk("flush_idle_busy", 64'(busy), 64'd0);
        tick;
        chk("flush_idle_done", 64'(done), 64'd0);

        // Asynchronous reset at cycle 20
        op = 2'b00; src1 = 32'd4; src2 = 32'd4; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (19) tick;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        e_lo = '0; e_hi = '0; e_n = 1'b0; e_z = 1'b0;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk_outs("arst");
        tick;
        rst = 1'b0;
        tick;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_done", 64'(done), 64'd0);

        // Random ops
        for (int i = 0; i < 16; i++) begin
            run_op(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
